insn_fetch_queue: RTL and testbench
===================================

// Module: insn_fetch_queue
// PURPOSE
//  Fetch stage that sits directly upstream of the single-cycle datapath decode.
//  Issues word-aligned PCs to the imem read port; imem returns data one cycle later.
//  Buffers {pc, insn} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
//  A redirect (taken branch/jump) flushes all buffered and in-flight fetches and restarts at the target.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of 2, >= 2
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  halt_fetch      in   1   stop issuing new fetches (ecall halt); in-flight fetch still completes
//  pc_to_imem      out  32  fetch address, always [1:0]==2'b00
//  imem_req_valid  out  1   a fetch is issued this cycle at pc_to_imem
//  insn_from_imem  in   32  imem data; valid the cycle after imem_req_valid
//  redirect_valid  in   1   decode requests a control-flow change this cycle
//  redirect_pc     in   32  redirect target
//  redirect_misal  out  1   registered pulse: last redirect_pc had [1:0]!=0
//  out_valid       out  1   head entry available to decode
//  out_pc          out  32  PC of head entry
//  out_insn        out  32  instruction of head entry
//  out_ready       in   1   decode consumes head when out_valid && out_ready
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; FIFO empty; in-flight cleared; out_valid=0, out_pc=0, out_insn=0,
//    imem_req_valid=0, redirect_misal=0. pc_to_imem=fetch_pc (RESET_PC).
//  - pop = out_valid && out_ready && !redirect_valid (a pop in a redirect cycle is ignored).
//  - issue = !rst && !halt_fetch && !redirect_valid && (count + inflight - pop) < DEPTH.
//    On issue: imem_req_valid=1, pc_to_imem=fetch_pc; fetch_pc<=fetch_pc+4 (wraps mod 2^32);
//    inflight<=1, inflight_pc<=fetch_pc. No issue: inflight<=0.
//  - Response: cycle after issue, if inflight && !redirect_valid, push {inflight_pc, insn_from_imem}.
//  - count_next = count + push - pop; push never overflows (guaranteed by issue rule).
//    Push and pop in the same cycle on a full FIFO are legal; count unchanged.
//  - out_valid = (count != 0); out_pc/out_insn come from the head entry; registered, no comb path
//    from insn_from_imem to out_*. First insn visible 2 cycles after rst deassert.
//  - Steady state with out_ready=1, no redirect: one insn per cycle for any DEPTH>=2.
//  - Redirect: same cycle flush FIFO (count<=0, ptrs<=0), drop in-flight response, fetch_pc<=
//    {redirect_pc[31:2],2'b00}, no issue. Issue at the new target the following cycle.
//    redirect_misal<=|redirect_pc[1:0] (else 0 every cycle).
//  - halt_fetch: no new issue; the in-flight response is still pushed; FIFO drains normally.
//    Deassert resumes at current fetch_pc.
//  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  - rst mid-operation overrides all: in-flight response on the following cycle is dropped.
// STRUCTURE
//  - fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] insn;} fetch_entry_t;
//    localparam logic [31:0] FetchStride = 32'd4.
//  - One sub-module: fetch_fifo #(DEPTH, fetch_entry_t): sync FIFO with push/pop/flush and count.
//  - Top level holds fetch_pc, inflight/inflight_pc, issue/redirect control.
// TESTING
//  1 Reset release, out_ready=1, imem returns mem[pc>>2]: out_pc 0,4,8,... on consecutive
//    cycles starting 2 cycles after reset; no bubbles.
//  2 out_ready=0 for 10 cycles: exactly DEPTH entries buffered, imem_req_valid low once full;
//    out_ready=1 then yields PCs in order, none lost or duplicated.
//  3 redirect_valid with redirect_pc=0x100 while FIFO holds 3 entries and one fetch is in flight:
//    next out_valid entry has out_pc=0x100; stale PCs never appear.
//  4 redirect_pc=0x202: fetch restarts at 0x200, redirect_misal=1 for exactly one cycle.
//  5 halt_fetch asserted right after an issue: that insn is delivered, then imem_req_valid stays 0
//    and out_valid drops after the FIFO drains.
//  6 rst asserted mid-stream with full FIFO: next cycle out_valid=0, pc_to_imem=RESET_PC, and the
//    insn in flight at reset never appears.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// An entry pairs a fetch address with the instruction word returned for it.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

   localparam logic [31:0] FetchStride = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a single-cycle flush, holding fetched {pc, insn} pairs.
// The head entry is read straight from storage registers, so there is no path from push_data to head.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      push,
   input  entry_t                    push_data,
   input  logic                      pop,
   output entry_t                    head,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/insn_fetch_queue.sv
// Fetch stage: issues word-aligned PCs to imem, buffers {pc, insn} pairs and hands them to decode.
// A redirect flushes buffered and in-flight fetches and restarts at the aligned target.
module insn_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt_fetch,
   output logic [31:0] pc_to_imem,
   output logic        imem_req_valid,
   input  logic [31:0] insn_from_imem,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        redirect_misal,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_insn,
   input  logic        out_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [31:0]  fetch_pc;
   logic [31:0]  inflight_pc;
   logic         inflight;
   logic         issue;
   logic         push;
   logic         pop;
   logic         empty;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   fetch_entry_t head;
   fetch_entry_t push_entry;

   // Occupancy counts the slot reserved by an in-flight fetch, net of this cycle's pop,
   // so a returning response always has room and back-to-back issue never overflows.
   assign pop       = out_valid && out_ready && !redirect_valid;
   assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue     = !rst && !halt_fetch && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
   assign push      = inflight && !redirect_valid;

   assign imem_req_valid = issue;
   assign pc_to_imem     = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc       <= align_word(RESET_PC);
         inflight       <= 1'b0;
         inflight_pc    <= '0;
         redirect_misal <= 1'b0;
      end else begin
         redirect_misal <= redirect_valid && (|redirect_pc[1:0]);
         inflight       <= issue;
         if (redirect_valid) begin
            fetch_pc <= align_word(redirect_pc);
         end else if (issue) begin
            fetch_pc    <= fetch_pc + FetchStride;
            inflight_pc <= fetch_pc;
         end
      end
   end

   always_comb begin
      push_entry      = '0;
      push_entry.pc   = inflight_pc;
      push_entry.insn = insn_from_imem;
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty)
   );

   // Outputs read as zero while empty so decode never sees a stale head.
   assign out_valid = !empty;
   assign out_pc    = out_valid ? head.pc   : '0;
   assign out_insn  = out_valid ? head.insn : '0;

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: directed scenarios followed by random traffic, checked by a
// scoreboard holding the expected sequential PC stream that restarts on redirect or reset.
module tb_insn_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt_fetch;
   logic [31:0] pc_to_imem;
   logic        imem_req_valid;
   logic [31:0] insn_from_imem;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_misal;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_insn;
   logic        out_ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pops   = 0;
   int          n_req;
   logic        got;
   logic        started  = 1'b0;
   logic        misal_exp = 1'b0;
   logic        misal_exp_prev = 1'b0;
   logic [31:0] exp_q [$];
   logic [31:0] gen_pc = RESET_PC;

   logic        r_rst, r_halt, r_rv, r_rdy;
   logic [31:0] r_rpc;

   always #5 clk = ~clk;

   insn_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .halt_fetch     (halt_fetch),
      .pc_to_imem     (pc_to_imem),
      .imem_req_valid (imem_req_valid),
      .insn_from_imem (insn_from_imem),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_misal (redirect_misal),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_insn       (out_insn),
      .out_ready      (out_ready)
   );

   function automatic logic [31:0] imem_word(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle of stimulus; the expected stream restarts on reset or redirect.
   task automatic drive(input logic r, input logic h, input logic rv, input logic [31:0] rpc,
                        input logic rdy);
      @(posedge clk);
      #1;
      rst            = r;
      halt_fetch     = h;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      if (r) begin
         exp_q.delete();
         gen_pc = RESET_PC;
      end else if (rv) begin
         exp_q.delete();
         gen_pc = {rpc[31:2], 2'b00};
      end
      while (exp_q.size() < 16) begin
         exp_q.push_back(gen_pc);
         gen_pc += 32'd4;
      end
      misal_exp_prev = misal_exp;
      misal_exp      = !r && rv && (|rpc[1:0]);
      started        = 1'b1;
   endtask

   // imem: data for the address requested in one cycle appears in the next; garbage otherwise.
   initial begin : imem_model
      logic        req;
      logic [31:0] addr;
      insn_from_imem = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         req  = imem_req_valid;
         addr = pc_to_imem;
         @(posedge clk);
         #1;
         insn_from_imem = req ? imem_word(addr) : $urandom();
      end
   end

   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (started) begin
            check("misal_pulse", {31'd0, redirect_misal}, {31'd0, misal_exp_prev});
         end
         if (started && !rst && imem_req_valid) begin
            check("pc_align", {30'd0, pc_to_imem[1:0]}, 32'd0);
         end
         if (started && !rst && out_valid && out_ready && !redirect_valid) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_empty: got pc %h expected no entry", out_pc);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", out_pc, e);
               check("sb_insn", out_insn, imem_word(e));
            end
         end
      end
   end

   initial begin : stimulus
      rst            = 1'b1;
      halt_fetch     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;

      repeat (3) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_insn", out_insn, 32'd0);
      check("rst_req", {31'd0, imem_req_valid}, 32'd0);
      check("rst_misal", {31'd0, redirect_misal}, 32'd0);
      check("rst_pc_to_imem", pc_to_imem, RESET_PC);

      // 1: first insn two cycles after release, then one per cycle
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t1_req_c0", {31'd0, imem_req_valid}, 32'd1);
      check("t1_pc_c0", pc_to_imem, RESET_PC);
      check("t1_valid_c0", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t1_valid_c1", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         check("t1_valid", {31'd0, out_valid}, 32'd1);
         check("t1_pc", out_pc, RESET_PC + 32'(4 * i));
      end

      // 2: stall decode; exactly DEPTH fetches fill the queue, then drain in order
      drive(1'b0, 1'b0, 1'b1, 32'h1000, 1'b0);
      n_req = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         @(negedge clk);
         if (imem_req_valid) n_req++;
      end
      check("t2_issue_count", n_req, DEPTH);
      check("t2_req_stalled", {31'd0, imem_req_valid}, 32'd0);
      check("t2_head_pc", out_pc, 32'h1000);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         check("t2_drain_pc", out_pc, 32'h1000 + 32'(4 * i));
      end

      // 3: redirect with three entries buffered and one fetch in flight
      drive(1'b0, 1'b0, 1'b1, 32'h2000, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("t3_pre_req", {31'd0, imem_req_valid}, 32'd1);
      drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            check("t3_first_pc", out_pc, 32'h100);
            check("t3_first_insn", out_insn, imem_word(32'h100));
         end
      end
      check("t3_seen_valid", {31'd0, got}, 32'd1);

      // 4: misaligned target restarts at the aligned word with a one-cycle flag
      drive(1'b0, 1'b0, 1'b1, 32'h202, 1'b1);
      @(negedge clk);
      check("t4_misal_same", {31'd0, redirect_misal}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t4_misal_set", {31'd0, redirect_misal}, 32'd1);
      check("t4_pc", pc_to_imem, 32'h200);
      check("t4_req", {31'd0, imem_req_valid}, 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t4_misal_clr", {31'd0, redirect_misal}, 32'd0);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // 5: halt right after an issue; in-flight insn delivered, then the queue drains
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t5_pre_issue", {31'd0, imem_req_valid}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         check("t5_halt_req", {31'd0, imem_req_valid}, 32'd0);
      end
      check("t5_drained", {31'd0, out_valid}, 32'd0);
      repeat (6) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // 6: reset mid-stream with a fetch in flight
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      check("t6_req_in_rst", {31'd0, imem_req_valid}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      check("t6_valid_after", {31'd0, out_valid}, 32'd0);
      check("t6_pc_after", pc_to_imem, RESET_PC);
      repeat (4) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // random traffic
      r_halt = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 999) < 4);
         r_rv  = !r_rst && ($urandom_range(0, 99) < 5);
         r_rpc = $urandom() & 32'h0000_FFFF;
         r_rdy = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 99) < 8) r_halt = !r_halt;
         drive(r_rst, r_halt, r_rv, r_rpc, r_rdy);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      @(posedge clk);
      check("live_pops", {31'd0, (n_pops > 300)}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
